tangram_piece_ctrl: RTL and testbench
=====================================

Name: tangram_piece_ctrl

Overview:
- Upstream control stage for the tangram shape rasterizers.
- Debounces the player's push-buttons and keeps position (px, py) and orientation (toward) for each of the seven pieces.
- Drives the px/py/toward inputs of each per-piece shape instance.
- All updates are committed only on a frame tick (vertical blank), so no piece moves mid-frame.

Parameters:
- NUM_PIECES, 7, number of pieces; the select index wraps at NUM_PIECES-1.
- DEBOUNCE_CYCLES, 400000, cycles a synchronised button level must stay stable before it is accepted (10 ms at 40 MHz).
- STEP, 10, pixels moved per accepted direction press.
- X_MIN, 0 / X_MAX, 799, clamp range for px.
- Y_MIN, 0 / Y_MAX, 599, clamp range for py.

Ports:
- clk_40m  in  1  pixel clock; the only clock.
- rst  in  1  synchronous reset, active-high.
- btn  in  6  raw asynchronous buttons: [0] up, [1] down, [2] left, [3] right, [4] rotate, [5] select.
- frame_tick  in  1  one-cycle pulse at the start of vertical blank.
- sel  out  3  index of the currently selected piece.
- px_bus  out  77  11-bit px per piece; piece i occupies [11i+10:11i].
- py_bus  out  77  11-bit py per piece, same packing as px_bus.
- toward_bus  out  14  2-bit toward per piece; piece i occupies [2i+1:2i].
- busy  out  1  high while the state machine is in APPLY or ADVANCE.

Behaviour:
- Reset (synchronous, rst=1 at a clk_40m edge):
  - px/py of every piece load from the package constants INIT_PX[i] / INIT_PY[i].
  - toward = 0 for every piece; sel = 0; busy = 0.
  - Pending flags, debounce counters and stable levels are all cleared to 0.
  - Reset in the middle of APPLY or ADVANCE aborts the operation, returns to IDLE and discards all pending flags.
- Input sync: each btn bit passes through a 2-flop synchroniser.
- Debounce, per button:
  - If the synchronised level equals the stable level, the counter clears.
  - Otherwise the counter increments.
  - When the counter reaches DEBOUNCE_CYCLES-1, the stable level takes the synchronised level and the counter clears.
  - A press event is a 0->1 transition of the stable level.
  - Latency from a clean raw edge to the event is 2 + DEBOUNCE_CYCLES cycles.
- Pending flags: each press event sets that button's pending flag. Multiple presses of one button before a frame tick collapse into one action.
- State machine: IDLE, APPLY, ADVANCE.
  - IDLE: if frame_tick=1 and any pending flag is set, go to APPLY. A frame_tick with nothing pending is ignored.
  - APPLY (1 cycle): update piece[sel], then go to ADVANCE.
    - px/py: if up and down are both pending, py is unchanged; same for left with right on px. Otherwise:
      - up: py = max(py-STEP, Y_MIN).
      - down: py = min(py+STEP, Y_MAX).
      - left: px = max(px-STEP, X_MIN).
      - right: px = min(px+STEP, X_MAX).
    - Underflow check: if py < Y_MIN+STEP then py = Y_MIN; px uses X_MIN the same way. Never wrap to a large value.
    - toward: rotate pending gives toward = toward+1 mod 4 (3 wraps to 0).
    - Snapshot and clear the up/down/left/right/rotate pending flags. Select stays pending.
  - ADVANCE (1 cycle): if select is pending, sel = (sel == NUM_PIECES-1) ? 0 : sel+1, and the select flag clears. Return to IDLE.
    - Movement and rotation therefore act on the piece that was selected before the select press of the same frame.
- Simultaneous events: a press event arriving in the same cycle its flag is cleared stays set (set wins). It applies on the next frame.
- frame_tick arriving while busy is ignored.
- Every output is a register updated only in APPLY or ADVANCE. All other bus fields hold their values.

Decomposition:
- Package tangram_pkg holds:
  - button index constants BTN_UP..BTN_SEL;
  - state enum (IDLE, APPLY, ADVANCE);
  - INIT_PX / INIT_PY constant arrays (11-bit each);
  - COORD_W = 11 and DIR_W = 2.
- Sub-module btn_debounce (one instance per button) contains the synchroniser, the counter and a stable-level output plus a rise-pulse output.

Test Plan (DEBOUNCE_CYCLES=4, STEP=10):
- Reset: sel=0, every toward=0, px/py equal INIT_PX/INIT_PY, busy=0.
- Right on piece 0 at px=100:
  - Hold btn[3] for 10 cycles, then pulse frame_tick.
  - px_bus[10:0]=110 two cycles after the tick; the other pieces are unchanged.
- Bounce: toggle btn[0] every 2 cycles for 20 cycles, then release.
  - No press event occurs.
  - After a frame_tick, py is unchanged and busy is never asserted.
- Clamp:
  - Piece at py=5, up pressed, frame_tick: py=0.
  - Piece at px=795, right pressed, frame_tick: px=799.
- Combined events:
  - Select and rotate pressed with sel=6 and toward[6]=3: after frame_tick, toward[6]=0 and sel=0.
  - Left and right pressed together: px is unchanged.
- Reset mid-operation: assert rst in the APPLY cycle. All state returns to reset values and the pending move is not applied on the next frame_tick.

Source files
------------

// File: rtl/tangram_pkg.sv
// Shared constants, types and helpers for the tangram piece controller.
// Button indices, FSM states, initial piece placement, coordinate stepping.
package tangram_pkg;

    localparam int COORD_W = 11;
    localparam int DIR_W   = 2;
    localparam int NUM_BTN = 6;

    localparam int BTN_UP    = 0;
    localparam int BTN_DOWN  = 1;
    localparam int BTN_LEFT  = 2;
    localparam int BTN_RIGHT = 3;
    localparam int BTN_ROT   = 4;
    localparam int BTN_SEL   = 5;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_APPLY   = 2'd1,
        ST_ADVANCE = 2'd2
    } state_e;

    localparam logic [COORD_W-1:0] INIT_PX [7] = '{
        11'd100, 11'd200, 11'd300, 11'd400, 11'd500, 11'd600, 11'd795
    };
    localparam logic [COORD_W-1:0] INIT_PY [7] = '{
        11'd300, 11'd5, 11'd300, 11'd300, 11'd300, 11'd300, 11'd300
    };

    // One axis step with clamping; opposing requests cancel.
    // Done in int so a decrement below lo can never wrap.
    function automatic logic [COORD_W-1:0] step_coord(
        input logic [COORD_W-1:0] cur,
        input logic               dec,
        input logic               inc,
        input int                 lo,
        input int                 hi,
        input int                 step
    );
        int c;
        c = int'(cur);
        if (dec && !inc) begin
            return (c < lo + step) ? COORD_W'(lo) : COORD_W'(c - step);
        end
        if (inc && !dec) begin
            return (c + step > hi) ? COORD_W'(hi) : COORD_W'(c + step);
        end
        return cur;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Single-button 2-flop synchroniser plus stability-counter debouncer.
// Ports: clk, rst (sync, high), btn_raw in; stable level and rise pulse out.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 400000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic stable,
    output logic rise
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             s1_q, s2_q;
    logic             stable_q, stable_d;
    logic             rise_q, rise_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d    = '0;
        stable_d = stable_q;
        rise_d   = 1'b0;
        if (s2_q != stable_q) begin
            if (cnt_q == CNT_LAST) begin
                stable_d = s2_q;
                rise_d   = s2_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q     <= 1'b0;
            s2_q     <= 1'b0;
            stable_q <= 1'b0;
            rise_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            s1_q     <= btn_raw;
            s2_q     <= s1_q;
            stable_q <= stable_d;
            rise_q   <= rise_d;
            cnt_q    <= cnt_d;
        end
    end

    assign stable = stable_q;
    assign rise   = rise_q;

endmodule

// File: rtl/tangram_piece_ctrl.sv
// Debounced button control of seven tangram pieces, committed on frame tick.
// Ports: clk_40m, rst, btn[5:0], frame_tick in; sel, px/py/toward buses, busy out.
module tangram_piece_ctrl
    import tangram_pkg::*;
#(
    parameter int NUM_PIECES      = 7,
    parameter int DEBOUNCE_CYCLES = 400000,
    parameter int STEP            = 10,
    parameter int X_MIN           = 0,
    parameter int X_MAX           = 799,
    parameter int Y_MIN           = 0,
    parameter int Y_MAX           = 599
) (
    input  logic                          clk_40m,
    input  logic                          rst,
    input  logic [NUM_BTN-1:0]            btn,
    input  logic                          frame_tick,
    output logic [2:0]                    sel,
    output logic [NUM_PIECES*COORD_W-1:0] px_bus,
    output logic [NUM_PIECES*COORD_W-1:0] py_bus,
    output logic [NUM_PIECES*DIR_W-1:0]   toward_bus,
    output logic                          busy
);

    logic [NUM_BTN-1:0] lvl;
    logic [NUM_BTN-1:0] rise;
    logic [NUM_BTN-1:0] press_ev;

    for (genvar g = 0; g < NUM_BTN; g++) begin : g_db
        btn_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_db (
            .clk     (clk_40m),
            .rst     (rst),
            .btn_raw (btn[g]),
            .stable  (lvl[g]),
            .rise    (rise[g])
        );
    end

    // Rise pulse coincides with the new high level; the AND is a cheap
    // guard that an event is only taken while the level is still held.
    assign press_ev = rise & lvl;

    state_e               state_q, state_d;
    logic [NUM_BTN-1:0]   pend_q, pend_d;
    logic [2:0]           sel_q, sel_d;
    logic                 busy_q, busy_d;
    logic [COORD_W-1:0]   px_q [NUM_PIECES];
    logic [COORD_W-1:0]   px_d [NUM_PIECES];
    logic [COORD_W-1:0]   py_q [NUM_PIECES];
    logic [COORD_W-1:0]   py_d [NUM_PIECES];
    logic [DIR_W-1:0]     tw_q [NUM_PIECES];
    logic [DIR_W-1:0]     tw_d [NUM_PIECES];

    always_comb begin
        state_d = state_q;
        pend_d  = pend_q | press_ev;
        sel_d   = sel_q;
        px_d    = px_q;
        py_d    = py_q;
        tw_d    = tw_q;
        unique case (state_q)
            ST_IDLE: begin
                if (frame_tick && (|pend_q)) begin
                    state_d = ST_APPLY;
                end
            end
            ST_APPLY: begin
                for (int i = 0; i < NUM_PIECES; i++) begin
                    if (sel_q == 3'(i)) begin
                        px_d[i] = step_coord(px_q[i], pend_q[BTN_LEFT],
                                             pend_q[BTN_RIGHT], X_MIN, X_MAX, STEP);
                        py_d[i] = step_coord(py_q[i], pend_q[BTN_UP],
                                             pend_q[BTN_DOWN], Y_MIN, Y_MAX, STEP);
                        if (pend_q[BTN_ROT]) begin
                            tw_d[i] = tw_q[i] + DIR_W'(1);
                        end
                    end
                end
                // Consumed flags clear, but a fresh press this cycle wins.
                pend_d[BTN_ROT:BTN_UP] = press_ev[BTN_ROT:BTN_UP];
                state_d = ST_ADVANCE;
            end
            ST_ADVANCE: begin
                if (pend_q[BTN_SEL]) begin
                    sel_d = (sel_q == 3'(NUM_PIECES - 1)) ? 3'd0 : sel_q + 3'd1;
                    pend_d[BTN_SEL] = press_ev[BTN_SEL];
                end
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk_40m) begin
        if (rst) begin
            state_q <= ST_IDLE;
            pend_q  <= '0;
            sel_q   <= '0;
            busy_q  <= 1'b0;
            for (int i = 0; i < NUM_PIECES; i++) begin
                px_q[i] <= INIT_PX[i % $size(INIT_PX)];
                py_q[i] <= INIT_PY[i % $size(INIT_PY)];
                tw_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            sel_q   <= sel_d;
            busy_q  <= busy_d;
            px_q    <= px_d;
            py_q    <= py_d;
            tw_q    <= tw_d;
        end
    end

    always_comb begin
        px_bus     = '0;
        py_bus     = '0;
        toward_bus = '0;
        for (int i = 0; i < NUM_PIECES; i++) begin
            px_bus[COORD_W*i +: COORD_W]   = px_q[i];
            py_bus[COORD_W*i +: COORD_W]   = py_q[i];
            toward_bus[DIR_W*i +: DIR_W]   = tw_q[i];
        end
    end

    assign sel  = sel_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_tangram_piece_ctrl.sv
// Directed self-checking bench for tangram_piece_ctrl.
// Short debounce window; expected values are hand-derived constants.
module tb_tangram_piece_ctrl;

    logic        clk_40m = 1'b0;
    logic        rst = 1'b1;
    logic [5:0]  btn = '0;
    logic        frame_tick = 1'b0;
    logic [2:0]  sel;
    logic [76:0] px_bus;
    logic [76:0] py_bus;
    logic [13:0] toward_bus;
    logic        busy;

    int total = 0;
    int bad = 0;

    int exp_px [7];
    int exp_py [7];
    int exp_tw [7];
    int exp_sel;

    tangram_piece_ctrl #(
        .NUM_PIECES      (7),
        .DEBOUNCE_CYCLES (4),
        .STEP            (10),
        .X_MIN           (0),
        .X_MAX           (799),
        .Y_MIN           (0),
        .Y_MAX           (599)
    ) dut (
        .clk_40m    (clk_40m),
        .rst        (rst),
        .btn        (btn),
        .frame_tick (frame_tick),
        .sel        (sel),
        .px_bus     (px_bus),
        .py_bus     (py_bus),
        .toward_bus (toward_bus),
        .busy       (busy)
    );

    always #5 clk_40m = ~clk_40m;

    task automatic set_init();
        exp_px = '{100, 200, 300, 400, 500, 600, 795};
        exp_py = '{300, 5, 300, 300, 300, 300, 300};
        exp_tw = '{0, 0, 0, 0, 0, 0, 0};
        exp_sel = 0;
    endtask

    task automatic press(input logic [5:0] m);
        @(posedge clk_40m); #1;
        btn = m;
        repeat (10) @(posedge clk_40m);
        #1;
        btn = '0;
        repeat (10) @(posedge clk_40m);
    endtask

    // Leaves the caller #1 after the edge that sampled the tick.
    task automatic tick_pulse();
        @(posedge clk_40m); #1;
        frame_tick = 1'b1;
        @(posedge clk_40m); #1;
        frame_tick = 1'b0;
    endtask

    task automatic frame(input logic [5:0] m);
        press(m);
        tick_pulse();
        repeat (3) @(posedge clk_40m);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk_40m);
        #1;
        rst = 1'b0;
        set_init();
        total++;
        if (sel !== 3'(exp_sel)) begin
            bad++;
            $display("FAIL reset_sel got=%0d want=%0d", sel, exp_sel);
        end
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_busy got=%b want=0", busy);
        end
        for (int i = 0; i < 7; i++) begin
            total++;
            if (px_bus[11*i +: 11] !== 11'(exp_px[i]) ||
                py_bus[11*i +: 11] !== 11'(exp_py[i]) ||
                toward_bus[2*i +: 2] !== 2'(exp_tw[i])) begin
                bad++;
                $display("FAIL reset_piece%0d got=%0d,%0d,%0d want=%0d,%0d,%0d", i,
                         px_bus[11*i +: 11], py_bus[11*i +: 11], toward_bus[2*i +: 2],
                         exp_px[i], exp_py[i], exp_tw[i]);
            end
        end
    endtask

    task automatic test_right();
        press(6'b001000);
        tick_pulse();
        @(posedge clk_40m); #1;
        exp_px[0] = 110;
        total++;
        if (px_bus[10:0] !== 11'd110) begin
            bad++;
            $display("FAIL right_px0 got=%0d want=110", px_bus[10:0]);
        end
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL right_busy got=%b want=1", busy);
        end
        repeat (2) @(posedge clk_40m);
        #1;
        total++;
        if (busy !== 1'b0 || sel !== 3'd0) begin
            bad++;
            $display("FAIL right_idle got busy=%b sel=%0d want busy=0 sel=0", busy, sel);
        end
        for (int i = 0; i < 7; i++) begin
            total++;
            if (px_bus[11*i +: 11] !== 11'(exp_px[i]) ||
                py_bus[11*i +: 11] !== 11'(exp_py[i])) begin
                bad++;
                $display("FAIL right_piece%0d got=%0d,%0d want=%0d,%0d", i,
                         px_bus[11*i +: 11], py_bus[11*i +: 11], exp_px[i], exp_py[i]);
            end
        end
    endtask

    task automatic test_bounce();
        @(posedge clk_40m); #1;
        for (int k = 0; k < 10; k++) begin
            btn[0] = ~btn[0];
            repeat (2) @(posedge clk_40m);
            #1;
        end
        btn = '0;
        repeat (10) @(posedge clk_40m);
        tick_pulse();
        for (int k = 0; k < 4; k++) begin
            total++;
            if (busy !== 1'b0) begin
                bad++;
                $display("FAIL bounce_busy cyc=%0d got=%b want=0", k, busy);
            end
            @(posedge clk_40m); #1;
        end
        total++;
        if (py_bus[10:0] !== 11'(exp_py[0])) begin
            bad++;
            $display("FAIL bounce_py0 got=%0d want=%0d", py_bus[10:0], exp_py[0]);
        end
    endtask

    task automatic test_clamp();
        frame(6'b100000);
        exp_sel = 1;
        total++;
        if (sel !== 3'd1) begin
            bad++;
            $display("FAIL clamp_sel1 got=%0d want=1", sel);
        end
        frame(6'b100001);
        exp_py[1] = 0;
        exp_sel = 2;
        total++;
        if (py_bus[21:11] !== 11'd0 || sel !== 3'd2) begin
            bad++;
            $display("FAIL clamp_up got py1=%0d sel=%0d want py1=0 sel=2",
                     py_bus[21:11], sel);
        end
        for (int k = 0; k < 4; k++) frame(6'b100000);
        exp_sel = 6;
        total++;
        if (sel !== 3'd6) begin
            bad++;
            $display("FAIL clamp_sel6 got=%0d want=6", sel);
        end
        frame(6'b001000);
        exp_px[6] = 799;
        total++;
        if (px_bus[76:66] !== 11'd799) begin
            bad++;
            $display("FAIL clamp_right got=%0d want=799", px_bus[76:66]);
        end
    endtask

    task automatic test_combined();
        for (int k = 0; k < 3; k++) frame(6'b010000);
        exp_tw[6] = 3;
        total++;
        if (toward_bus[13:12] !== 2'd3) begin
            bad++;
            $display("FAIL comb_tw3 got=%0d want=3", toward_bus[13:12]);
        end
        frame(6'b110000);
        exp_tw[6] = 0;
        exp_sel = 0;
        total++;
        if (toward_bus[13:12] !== 2'd0 || sel !== 3'd0) begin
            bad++;
            $display("FAIL comb_selrot got tw6=%0d sel=%0d want tw6=0 sel=0",
                     toward_bus[13:12], sel);
        end
        frame(6'b001100);
        total++;
        if (px_bus[10:0] !== 11'(exp_px[0]) || py_bus[10:0] !== 11'(exp_py[0])) begin
            bad++;
            $display("FAIL comb_lr got=%0d,%0d want=%0d,%0d",
                     px_bus[10:0], py_bus[10:0], exp_px[0], exp_py[0]);
        end
        for (int i = 0; i < 7; i++) begin
            total++;
            if (px_bus[11*i +: 11] !== 11'(exp_px[i]) ||
                py_bus[11*i +: 11] !== 11'(exp_py[i]) ||
                toward_bus[2*i +: 2] !== 2'(exp_tw[i])) begin
                bad++;
                $display("FAIL comb_piece%0d got=%0d,%0d,%0d want=%0d,%0d,%0d", i,
                         px_bus[11*i +: 11], py_bus[11*i +: 11], toward_bus[2*i +: 2],
                         exp_px[i], exp_py[i], exp_tw[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        press(6'b001000);
        tick_pulse();
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL mid_busy got=%b want=1", busy);
        end
        rst = 1'b1;
        @(posedge clk_40m); #1;
        rst = 1'b0;
        set_init();
        total++;
        if (busy !== 1'b0 || sel !== 3'd0 || px_bus[10:0] !== 11'd100) begin
            bad++;
            $display("FAIL mid_reset got busy=%b sel=%0d px0=%0d want 0,0,100",
                     busy, sel, px_bus[10:0]);
        end
        for (int i = 0; i < 7; i++) begin
            total++;
            if (px_bus[11*i +: 11] !== 11'(exp_px[i]) ||
                py_bus[11*i +: 11] !== 11'(exp_py[i]) ||
                toward_bus[2*i +: 2] !== 2'(exp_tw[i])) begin
                bad++;
                $display("FAIL mid_piece%0d got=%0d,%0d,%0d want=%0d,%0d,%0d", i,
                         px_bus[11*i +: 11], py_bus[11*i +: 11], toward_bus[2*i +: 2],
                         exp_px[i], exp_py[i], exp_tw[i]);
            end
        end
        repeat (4) @(posedge clk_40m);
        tick_pulse();
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL mid_tick_busy got=%b want=0", busy);
        end
        repeat (3) @(posedge clk_40m);
        #1;
        total++;
        if (px_bus[10:0] !== 11'd100) begin
            bad++;
            $display("FAIL mid_no_apply got=%0d want=100", px_bus[10:0]);
        end
    endtask

    initial begin
        test_reset();
        test_right();
        test_bounce();
        test_clamp();
        test_combined();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
